// File: rtl/param_sync_fifo.sv
// param_sync_fifo: synchronous FIFO with occupancy count, almost-full/empty flags and sticky overflow/underflow; define PARAM_SYNC_FIFO_FWFT_EN for first-word-fall-through rdata
module param_sync_fifo #(
    parameter int DSIZE    = 8,
    parameter int ASIZE    = 4,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    input  logic             rinc,
    input  logic             err_clr,
    output logic [DSIZE-1:0] rdata,
    output logic             wfull,
    output logic             rempty,
    output logic             walmost_full,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);
    localparam logic [ASIZE:0] AF = (ASIZE+1)'(AF_LEVEL);
    localparam logic [ASIZE:0] AE = (ASIZE+1)'(AE_LEVEL);

    if (AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > 2**ASIZE) begin : g_bad_levels
        $error("param_sync_fifo: need 0 <= AE_LEVEL < AF_LEVEL <= 2**ASIZE");
    end

    logic [DSIZE-1:0] mem [2**ASIZE];
    logic [ASIZE:0]   wptr, rptr;
    logic             wr_ok, rd_ok;

    // Extra pointer bit distinguishes full from empty, so the difference is the occupancy.
    assign count         = wptr - rptr;
    assign wfull         = count[ASIZE];
    assign rempty        = count == '0;
    assign walmost_full  = count >= AF;
    assign ralmost_empty = count <= AE;
    assign wr_ok         = winc & ~wfull;
    assign rd_ok         = rinc & ~rempty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
            overflow  <= (winc & wfull) | (overflow & ~err_clr);
            underflow <= (rinc & rempty) | (underflow & ~err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr[ASIZE-1:0]] <= wdata;
    end

`ifdef PARAM_SYNC_FIFO_FWFT_EN
    assign rdata = rempty ? '0 : mem[rptr[ASIZE-1:0]];
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata <= '0;
        else if (rd_ok) rdata <= mem[rptr[ASIZE-1:0]];
    end
`endif
endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: randomized scoreboard bench for param_sync_fifo against a queue-based reference model
module tb_param_sync_fifo;
    localparam int DEPTH = 16;
    localparam int AFL   = 12;
    localparam int AEL   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wdata = '0;
    logic       winc = 1'b0, rinc = 1'b0, err_clr = 1'b0;
    logic [7:0] rdata;
    logic       wfull, rempty, walmost_full, ralmost_empty, overflow, underflow;
    logic [4:0] count;

    param_sync_fifo #(.DSIZE(8), .ASIZE(4), .AF_LEVEL(AFL), .AE_LEVEL(AEL)) dut (
        .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .rinc(rinc), .err_clr(err_clr),
        .rdata(rdata), .wfull(wfull), .rempty(rempty), .walmost_full(walmost_full),
        .ralmost_empty(ralmost_empty), .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0] model_q[$];
    logic [7:0] exp_q[$];
    logic       m_ovf = 1'b0, m_udf = 1'b0;
    logic       rd_fire = 1'b0;
    logic       in_reset = 1'b1;
    logic [7:0] held = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of requests and advance the model to the state after the coming edge.
    task automatic cyc(input logic w, input logic r, input logic [7:0] d, input logic c);
        int sz;
        @(negedge clk);
        winc = w; rinc = r; wdata = d; err_clr = c;
        sz = model_q.size();
        m_ovf = (w && sz == DEPTH) || (m_ovf && !c);
        m_udf = (r && sz == 0) || (m_udf && !c);
        rd_fire = r && sz > 0;
        if (rd_fire) exp_q.push_back(model_q.pop_front());
        if (w && sz < DEPTH) model_q.push_back(d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_reset = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_rempty", 32'(rempty), 1);
        chk("rst_ralmost_empty", 32'(ralmost_empty), 1);
        chk("rst_wfull", 32'(wfull), 0);
        chk("rst_walmost_full", 32'(walmost_full), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_underflow", 32'(underflow), 0);
        chk("rst_rdata", 32'(rdata), 0);
        model_q.delete(); exp_q.delete();
        m_ovf = 1'b0; m_udf = 1'b0; rd_fire = 1'b0; held = '0;
        winc = 1'b0; rinc = 1'b0; err_clr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        in_reset = 1'b0;
    endtask

    // Monitor: compare DUT state just after each edge; pops the scoreboard on every accepted read.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!in_reset) begin
                int sz;
                sz = model_q.size();
                chk("count", 32'(count), 32'(sz));
                chk("wfull", 32'(wfull), 32'(sz == DEPTH));
                chk("rempty", 32'(rempty), 32'(sz == 0));
                chk("walmost_full", 32'(walmost_full), 32'(sz >= AFL));
                chk("ralmost_empty", 32'(ralmost_empty), 32'(sz <= AEL));
                chk("overflow", 32'(overflow), 32'(m_ovf));
                chk("underflow", 32'(underflow), 32'(m_udf));
                if (rd_fire) begin
                    if (exp_q.size() == 0) chk("scoreboard_empty", 1, 0);
                    else held = exp_q.pop_front();
                end
`ifdef PARAM_SYNC_FIFO_FWFT_EN
                chk("rdata_fwft", 32'(rdata), sz > 0 ? 32'(model_q[0]) : 0);
`else
                chk("rdata", 32'(rdata), 32'(held));
`endif
            end
        end
    end

    initial begin
        int pw, pr;
        #3;
        do_reset();
        for (int i = 1; i <= 16; i++) cyc(1, 0, 8'(i), 0);
        cyc(1, 0, 8'hAA, 0);
        cyc(0, 0, 8'h00, 1);
        for (int i = 0; i < 16; i++) cyc(0, 1, 8'h00, 0);
        cyc(0, 1, 8'h00, 0);
        cyc(0, 0, 8'h00, 1);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 10; i++) cyc(1, 0, 8'($urandom), 0);
            for (int i = 0; i < 10; i++) cyc(0, 1, 8'h00, 0);
        end
        for (int i = 0; i < 16; i++) cyc(1, 0, 8'($urandom), 0);
        cyc(1, 1, 8'h77, 0);
        cyc(0, 0, 8'h00, 1);
        for (int i = 0; i < 15; i++) cyc(0, 1, 8'h00, 0);
        cyc(1, 1, 8'h5A, 0);
        cyc(0, 0, 8'h00, 0);
        cyc(0, 1, 8'h00, 1);
        for (int seg = 0; seg < 40; seg++) begin
            pw = $urandom_range(10, 90);
            pr = $urandom_range(10, 90);
            for (int i = 0; i < 50; i++)
                cyc($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
                    8'($urandom), $urandom_range(0, 15) == 0);
            if (seg % 10 == 9) do_reset();
        end
        cyc(0, 0, 8'h00, 0);
        cyc(0, 0, 8'h00, 0);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
